// File: rtl/fetch_unit.sv
// Instruction fetch FSM: issues one memory read per instruction, presents ir/ir_pc to decode and steers the PC register.
// Latency: 2 cycles per instruction with zero-wait memory. Backpressure: ir_ready=0 holds FULL and no new read is issued.
module fetch_unit #(
    parameter logic [15:0] IR_RESET = 16'h0000
) (
    input  logic        Clk,
    input  logic        Reset_al,
    input  logic        fetch_en,
    input  logic [15:0] PC,
    output logic        LD_PC,
    output logic [1:0]  PCMUX,
    input  logic        redirect,
    input  logic [1:0]  redirect_src,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rdy,
    output logic [15:0] ir,
    output logic [15:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        FULL  = 2'b10,
        DRAIN = 2'b11
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_mem_addr;
    logic [15:0] r_ir;
    logic [15:0] r_ir_pc;
    logic        r_ir_valid;

    logic        w_load_addr;
    logic        w_load_ir;
    logic        w_clr_valid;

    always_comb begin
        w_next      = r_state;
        LD_PC       = 1'b0;
        PCMUX       = 2'b00;
        w_load_addr = 1'b0;
        w_load_ir   = 1'b0;
        w_clr_valid = 1'b0;

        if (Reset_al) begin
            // A redirect owns the PC load for this cycle and kills any live instruction.
            if (redirect) begin
                LD_PC       = 1'b1;
                PCMUX       = redirect_src;
                w_clr_valid = 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (!redirect && fetch_en) begin
                        w_next      = WAIT;
                        w_load_addr = 1'b1;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        w_next = mem_rdy ? IDLE : DRAIN;
                    end else if (mem_rdy) begin
                        LD_PC     = 1'b1;
                        w_load_ir = 1'b1;
                        w_next    = FULL;
                    end
                end
                FULL: begin
                    if (redirect) begin
                        w_next = IDLE;
                    end else if (ir_ready) begin
                        w_clr_valid = 1'b1;
                        if (fetch_en) begin
                            w_next      = WAIT;
                            w_load_addr = 1'b1;
                        end else begin
                            w_next = IDLE;
                        end
                    end
                end
                DRAIN: begin
                    // Stale read completes here; a redirect alone keeps us waiting for it.
                    if (mem_rdy) begin
                        w_next = IDLE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_al) begin
            r_state    <= IDLE;
            r_mem_addr <= 16'h0000;
            r_ir       <= IR_RESET;
            r_ir_pc    <= 16'h0000;
            r_ir_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load_addr) begin
                r_mem_addr <= PC;
            end
            if (w_load_ir) begin
                r_ir    <= mem_rdata;
                r_ir_pc <= r_mem_addr;
            end
            if (w_load_ir) begin
                r_ir_valid <= 1'b1;
            end else if (w_clr_valid) begin
                r_ir_valid <= 1'b0;
            end
        end
    end

    assign mem_rd   = Reset_al & ((r_state == WAIT) || (r_state == DRAIN));
    assign mem_addr = r_mem_addr;
    assign ir       = r_ir;
    assign ir_pc    = r_ir_pc;
    assign ir_valid = r_ir_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, fetch, memory wait, decode stall, redirects and reset mid-read.
module tb_fetch_unit;

    localparam logic [15:0] IRR = 16'hA5A5;

    logic        Clk = 1'b0;
    logic        Reset_al;
    logic        fetch_en;
    logic [15:0] PC;
    logic        LD_PC;
    logic [1:0]  PCMUX;
    logic        redirect;
    logic [1:0]  redirect_src;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_rdy;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;

    int compared   = 0;
    int mismatched = 0;
    int rd_cycles;
    int ld_pulses;

    fetch_unit #(.IR_RESET(IRR)) dut (
        .Clk          (Clk),
        .Reset_al     (Reset_al),
        .fetch_en     (fetch_en),
        .PC           (PC),
        .LD_PC        (LD_PC),
        .PCMUX        (PCMUX),
        .redirect     (redirect),
        .redirect_src (redirect_src),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_rdata    (mem_rdata),
        .mem_rdy      (mem_rdy),
        .ir           (ir),
        .ir_pc        (ir_pc),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_al = 1'b0; fetch_en = 1'b0; PC = 16'h0000; redirect = 1'b0;
        redirect_src = 2'b00; mem_rdata = 16'h0000; mem_rdy = 1'b0; ir_ready = 1'b0;
        tick();
        redirect = 1'b1; redirect_src = 2'b10; #1;
        chk("rst_ld_pc", 16'(LD_PC), 16'h0);
        chk("rst_pcmux", 16'(PCMUX), 16'h0);
        chk("rst_mem_rd", 16'(mem_rd), 16'h0);
        tick();
        redirect = 1'b0; Reset_al = 1'b1; #1;
        chk("rst_ir", ir, IRR);
        chk("rst_ir_pc", ir_pc, 16'h0000);
        chk("rst_ir_valid", 16'(ir_valid), 16'h0);
        chk("rst_mem_addr", mem_addr, 16'h0000);

        // Basic fetch
        PC = 16'h3000; fetch_en = 1'b1;
        tick();
        chk("bf_mem_addr", mem_addr, 16'h3000);
        chk("bf_mem_rd", 16'(mem_rd), 16'h1);
        mem_rdy = 1'b1; mem_rdata = 16'h1234; ir_ready = 1'b1; #1;
        chk("bf_ld_pc", 16'(LD_PC), 16'h1);
        chk("bf_pcmux", 16'(PCMUX), 16'h0);
        tick();
        mem_rdy = 1'b0; PC = 16'h3001; #1;
        chk("bf_ir", ir, 16'h1234);
        chk("bf_ir_pc", ir_pc, 16'h3000);
        chk("bf_ir_valid", 16'(ir_valid), 16'h1);
        chk("bf_mem_rd_full", 16'(mem_rd), 16'h0);
        chk("bf_no_ld_full", 16'(LD_PC), 16'h0);
        tick();
        chk("bf_next_addr", mem_addr, 16'h3001);
        chk("bf_valid_clr", 16'(ir_valid), 16'h0);

        // Memory wait: three stall cycles, completion on the fourth
        rd_cycles = 0; ld_pulses = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (mem_rd) rd_cycles++;
            if (LD_PC) ld_pulses++;
            chk("mw_addr_stable", mem_addr, 16'h3001);
            tick();
        end
        mem_rdy = 1'b1; mem_rdata = 16'h5678; #1;
        if (mem_rd) rd_cycles++;
        if (LD_PC) ld_pulses++;
        chk("mw_rd_cycles", 16'(rd_cycles), 16'd4);
        chk("mw_ld_pulses", 16'(ld_pulses), 16'd1);
        tick();
        mem_rdy = 1'b0; PC = 16'h3002; ir_ready = 1'b0; #1;
        chk("mw_ir", ir, 16'h5678);
        chk("mw_ir_pc", ir_pc, 16'h3001);

        // Decode stall for five cycles
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("ds_ir", ir, 16'h5678);
            chk("ds_valid", 16'(ir_valid), 16'h1);
            chk("ds_mem_rd", 16'(mem_rd), 16'h0);
            chk("ds_ld_pc", 16'(LD_PC), 16'h0);
            tick();
        end
        ir_ready = 1'b1;
        tick();
        chk("ds_xfer_addr", mem_addr, 16'h3002);
        chk("ds_xfer_valid", 16'(ir_valid), 16'h0);

        // Redirect during WAIT with memory still busy
        redirect = 1'b1; redirect_src = 2'b01; #1;
        chk("rw_ld_pc", 16'(LD_PC), 16'h1);
        chk("rw_pcmux", 16'(PCMUX), 16'h1);
        tick();
        redirect = 1'b0; PC = 16'h4000; #1;
        chk("rw_drain_rd", 16'(mem_rd), 16'h1);
        chk("rw_drain_addr", mem_addr, 16'h3002);
        tick();
        mem_rdy = 1'b1; mem_rdata = 16'hDEAD; #1;
        chk("rw_drain_no_ld", 16'(LD_PC), 16'h0);
        tick();
        mem_rdy = 1'b0; #1;
        chk("rw_idle_rd", 16'(mem_rd), 16'h0);
        chk("rw_ir_not_dead", ir, 16'h5678);
        chk("rw_valid", 16'(ir_valid), 16'h0);
        tick();
        chk("rw_new_addr", mem_addr, 16'h4000);
        mem_rdy = 1'b1; mem_rdata = 16'h0BEE;
        tick();
        mem_rdy = 1'b0; PC = 16'h4001; #1;
        chk("rw_ir", ir, 16'h0BEE);
        chk("rw_ir_pc", ir_pc, 16'h4000);

        // Redirect coinciding with the decode transfer
        redirect = 1'b1; redirect_src = 2'b10; #1;
        chk("rx_ld_pc", 16'(LD_PC), 16'h1);
        chk("rx_pcmux", 16'(PCMUX), 16'h2);
        tick();
        redirect = 1'b0; PC = 16'h5000; #1;
        chk("rx_valid", 16'(ir_valid), 16'h0);
        chk("rx_idle_rd", 16'(mem_rd), 16'h0);
        tick();
        chk("rx_refetch", mem_addr, 16'h5000);

        // Redirect coinciding with mem_rdy
        redirect = 1'b1; redirect_src = 2'b10; mem_rdy = 1'b1; mem_rdata = 16'hBAD1; #1;
        chk("rm_ld_pc", 16'(LD_PC), 16'h1);
        chk("rm_pcmux", 16'(PCMUX), 16'h2);
        tick();
        redirect = 1'b0; mem_rdy = 1'b0; fetch_en = 1'b0; #1;
        chk("rm_valid", 16'(ir_valid), 16'h0);
        chk("rm_ir_kept", ir, 16'h0BEE);
        chk("rm_idle_rd", 16'(mem_rd), 16'h0);

        // Illegal source forwarded unchanged from IDLE
        redirect = 1'b1; redirect_src = 2'b11; #1;
        chk("il_ld_pc", 16'(LD_PC), 16'h1);
        chk("il_pcmux", 16'(PCMUX), 16'h3);
        tick();
        redirect = 1'b0;

        // Redirect while draining stays in DRAIN until the read completes
        PC = 16'h6000; fetch_en = 1'b1;
        tick();
        redirect = 1'b1; redirect_src = 2'b01;
        tick();
        redirect_src = 2'b10; #1;
        chk("rd_ld_pc", 16'(LD_PC), 16'h1);
        chk("rd_pcmux", 16'(PCMUX), 16'h2);
        tick();
        redirect = 1'b0; #1;
        chk("rd_still_drain", 16'(mem_rd), 16'h1);
        chk("rd_addr", mem_addr, 16'h6000);
        mem_rdy = 1'b1;
        tick();
        mem_rdy = 1'b0; fetch_en = 1'b0; #1;
        chk("rd_idle", 16'(mem_rd), 16'h0);

        // Reset mid-WAIT followed by a late mem_rdy
        PC = 16'h7000; fetch_en = 1'b1;
        tick();
        chk("rr_wait_addr", mem_addr, 16'h7000);
        Reset_al = 1'b0; fetch_en = 1'b0; mem_rdy = 1'b1; mem_rdata = 16'hBEEF; #1;
        chk("rr_rst_rd", 16'(mem_rd), 16'h0);
        chk("rr_rst_ld", 16'(LD_PC), 16'h0);
        tick();
        Reset_al = 1'b1; #1;
        chk("rr_late_ld", 16'(LD_PC), 16'h0);
        chk("rr_ir", ir, IRR);
        chk("rr_valid", 16'(ir_valid), 16'h0);
        chk("rr_addr", mem_addr, 16'h0000);
        tick();
        mem_rdy = 1'b0; fetch_en = 1'b1; #1;
        chk("rr_ignored", 16'(ir_valid), 16'h0);
        chk("rr_idle_rd", 16'(mem_rd), 16'h0);
        tick();
        chk("rr_restart_addr", mem_addr, 16'h7000);
        chk("rr_restart_rd", 16'(mem_rd), 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: IR_RESET, default 16'h0000, the value loaded into ir on reset.
REQ-002 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Reset_al  input  1  synchronous, active-low reset, sampled on the rising edge of Clk.
REQ-004 fetch_en  input  1  permits new fetches to start.
REQ-005 PC  input  16  current program counter from the PC register.
REQ-006 LD_PC  output  1  load strobe to the PC register.
REQ-007 PCMUX  output  2  PC source select: 00 = PC+1, 01 = bus, 10 = offset.
REQ-008 redirect  input  1  branch/jump request from execute, single-cycle pulse.
REQ-009 redirect_src  input  2  PCMUX code for the redirect; only 01 and 10 are legal.
REQ-010 mem_addr  output  16  registered read address.
REQ-011 mem_rd  output  1  read request, held high until mem_rdy.
REQ-012 mem_rdata  input  16  read data, valid when mem_rdy=1.
REQ-013 mem_rdy  input  1  read completion, one cycle per read.
REQ-014 ir  output  16  fetched instruction.
REQ-015 ir_pc  output  16  address ir was fetched from.
REQ-016 ir_valid  output  1  ir/ir_pc hold a live instruction for decode.
REQ-017 ir_ready  input  1  decode accepts; the transfer occurs on any cycle where ir_valid and ir_ready are both 1.

Function
REQ-018 The FSM SHALL use the states IDLE, WAIT, FULL and DRAIN.
REQ-019 IDLE with fetch_en=1 SHALL register mem_addr<=PC and go to WAIT; IDLE with fetch_en=0 SHALL stay in IDLE.
REQ-020 mem_rd SHALL be 1 exactly in WAIT and DRAIN, and mem_addr SHALL stay stable while mem_rd=1.
REQ-021 WAIT with mem_rdy=1 (no redirect) SHALL, in one cycle: latch ir<=mem_rdata and ir_pc<=mem_addr; drive LD_PC=1 with PCMUX=00; set ir_valid=1; go to FULL.
REQ-022 WAIT with mem_rdy=0 (no redirect) SHALL hold state; there is no timeout.
REQ-023 FULL with ir_ready=1 and fetch_en=1 (no redirect) SHALL clear ir_valid, register mem_addr<=PC (already incremented) and go to WAIT, giving 1 instruction per 2 cycles with zero-wait memory.
REQ-024 FULL with ir_ready=1 and fetch_en=0 SHALL clear ir_valid and go to IDLE.
REQ-025 FULL with ir_ready=0 SHALL hold ir, ir_pc and ir_valid unchanged.
REQ-026 redirect=1 in any state SHALL:
  - drive LD_PC=1 with PCMUX=redirect_src that cycle;
  - clear ir_valid next cycle.
REQ-027 redirect SHALL take priority over the ir_valid/ir_ready transfer and over mem_rdy; PCMUX=00 is never driven in a redirect cycle.
REQ-028 Redirect next state:
  - from WAIT with mem_rdy=0: DRAIN;
  - from WAIT with mem_rdy=1: IDLE, read data discarded;
  - from IDLE or FULL: IDLE.
REQ-029 DRAIN SHALL keep mem_rd=1 until mem_rdy, discard mem_rdata and then go to IDLE; ir/ir_pc are not written.
REQ-030 redirect in DRAIN SHALL reload PC (REQ-026) and remain in DRAIN.
REQ-031 In every cycle not covered by REQ-021 or REQ-026, LD_PC SHALL be 0 and PCMUX SHALL be 00.
REQ-032 LD_PC and PCMUX SHALL be combinational from state and inputs; all other outputs SHALL be registered.
REQ-033 Address arithmetic is the PC register's job; 16'hFFFF wraps to 16'h0000 with no special handling here.
REQ-034 An illegal redirect_src (00 or 11) SHALL still be forwarded unchanged; the behaviour is the PC register's.

Reset
REQ-035 Reset_al=0 at a rising edge SHALL force state=IDLE, ir=IR_RESET, ir_pc=16'h0000, ir_valid=0 and mem_addr=16'h0000.
REQ-036 While reset is asserted, mem_rd and LD_PC SHALL be 0 and PCMUX SHALL be 00.
REQ-037 Reset mid-read SHALL abandon the outstanding read; a late mem_rdy in IDLE SHALL be ignored.

Verification
REQ-038 Basic fetch:
  - Stimulus: PC=16'h3000, fetch_en=1, zero-wait memory returning 16'h1234, ir_ready=1.
  - Response: mem_addr=3000, then ir=1234, ir_pc=3000, one LD_PC pulse with PCMUX=00.
  - Next: mem_addr=3001.
REQ-039 Memory wait:
  - Stimulus: mem_rdy delayed 3 cycles.
  - Response: mem_rd high for 4 cycles, mem_addr constant, exactly one LD_PC pulse.
REQ-040 Decode stall:
  - Stimulus: ir_ready=0 for 5 cycles in FULL.
  - Response: ir/ir_valid constant, mem_rd=0, no LD_PC; transfer on the first ir_ready=1.
REQ-041 Redirect during WAIT:
  - Stimulus: redirect=1, redirect_src=01 with mem_rdy=0.
  - Response: LD_PC=1 and PCMUX=01 that cycle; DRAIN discards 16'hDEAD; the next mem_addr equals the new PC (e.g. 4000); ir never shows DEAD.
REQ-042 Simultaneous events:
  - Stimulus: redirect=1 (src 10) in the same cycle as mem_rdy=1, and separately in the same cycle as the ir_valid/ir_ready transfer.
  - Response: PCMUX=10, no PC+1 load, ir_valid=0 next cycle, next state IDLE.
REQ-043 Reset mid-WAIT:
  - Stimulus: Reset_al=0 for 1 cycle, then mem_rdy pulse.
  - Response: ir=IR_RESET, ir_valid=0, no LD_PC, and the fetch restarts from the current PC.
